ps2_rx_fifo: RTL and testbench

PS/2 device-to-host receiver that sits upstream of the system block's keyboard/mouse input.
- Synchronises and glitch-filters the raw PS/2 clock and data lines.
- Deserialises 11-bit frames and checks start, parity and stop bits.
- Pushes good bytes into a small show-ahead FIFO that the CPU-side logic drains with a read strobe.
- Two instances are used, one for key_clk/key_data and one for mouse_clk/mouse_data.

---
 rtl/ps2_rx_fifo.sv | 172 +++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronises and glitch-filters the PS/2 lines, deserialises
// 11-bit frames, checks start/parity/stop and queues good bytes in a small show-ahead FIFO.
module ps2_rx_fifo #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 100000,
   parameter int FIFO_AW     = 2
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       rd_en,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       frame_err,
   output logic       overflow,
   output logic       busy
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int FW    = $clog2(FILTER_LEN + 1);
   localparam int TW    = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      CHECK
   } state_t;

   logic          clk_s1, clk_s2, dat_s1, dat_s2;
   logic          clk_f, clk_f_d, fall;
   logic [FW-1:0] flt_cnt;

   state_t        state;
   logic [3:0]    bit_cnt;
   logic [TW-1:0] tmo;
   logic [7:0]    shift_reg;
   logic          par_bit, stop_bit;
   logic          frame_good, push;

   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0]   count;
   logic               full, do_pop, wr_ok;

   // The filtered clock only follows the synced line after FILTER_LEN consecutive
   // disagreeing samples, so shorter glitches never reach the edge detector.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         clk_s1  <= 1'b1;
         clk_s2  <= 1'b1;
         dat_s1  <= 1'b1;
         dat_s2  <= 1'b1;
         clk_f   <= 1'b1;
         clk_f_d <= 1'b1;
         fall    <= 1'b0;
         flt_cnt <= '0;
      end else begin
         clk_s1  <= ps2_clk;
         clk_s2  <= clk_s1;
         dat_s1  <= ps2_data;
         dat_s2  <= dat_s1;
         clk_f_d <= clk_f;
         fall    <= clk_f_d & ~clk_f;
         if (clk_s2 != clk_f) begin
            if (flt_cnt == FW'(FILTER_LEN - 1)) begin
               clk_f   <= clk_s2;
               flt_cnt <= '0;
            end else begin
               flt_cnt <= flt_cnt + 1'b1;
            end
         end else begin
            flt_cnt <= '0;
         end
      end
   end

   assign frame_good = (^shift_reg ^ par_bit) & stop_bit;
   assign push       = (state == CHECK) & frame_good;

   // Bits 0-7 shift in LSB first, bit 8 is parity, bit 9 is stop; a stalled
   // frame is abandoned once the line has been quiet for TIMEOUT_CYC cycles.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         tmo       <= '0;
         shift_reg <= '0;
         par_bit   <= 1'b0;
         stop_bit  <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (fall && !dat_s2) begin
                  state   <= SHIFT;
                  busy    <= 1'b1;
                  bit_cnt <= '0;
                  tmo     <= '0;
               end
            end
            SHIFT: begin
               if (fall) begin
                  tmo     <= '0;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt < 4'd8) begin
                     shift_reg <= {dat_s2, shift_reg[7:1]};
                  end else if (bit_cnt == 4'd8) begin
                     par_bit <= dat_s2;
                  end else begin
                     stop_bit <= dat_s2;
                     state    <= CHECK;
                  end
               end else if (tmo == TW'(TIMEOUT_CYC - 1)) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  frame_err <= 1'b1;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            CHECK: begin
               state <= IDLE;
               busy  <= 1'b0;
               if (!frame_good) begin
                  frame_err <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign full     = (count == (FIFO_AW + 1)'(DEPTH));
   assign rd_valid = (count != '0);
   assign do_pop   = rd_en & rd_valid;
   assign wr_ok    = push & (~full | do_pop);
   assign rd_data  = mem[rd_ptr];

   // A push into a full FIFO is still accepted when a pop frees the head slot in the same cycle.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= push & full & ~do_pop;
         if (wr_ok) begin
            mem[wr_ptr] <= shift_reg;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (wr_ok && !do_pop) begin
            count <= count + 1'b1;
         end else if (!wr_ok && do_pop) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: frames are driven on the PS/2 pins, expected bytes and
// error/overflow pulses are predicted by a queue model and compared by an independent monitor.
module tb_ps2_rx_fifo;

   localparam int FILTER_LEN  = 8;
   localparam int TIMEOUT_CYC = 5000;
   localparam int FIFO_AW     = 2;
   localparam int DEPTH       = 4;

   logic       sys_clk   = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       ps2_clk   = 1'b1;
   logic       ps2_data  = 1'b1;
   logic       rd_en     = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid, frame_err, overflow, busy;

   int checks  = 0;
   int errors  = 0;
   int act_err = 0;
   int act_ovf = 0;
   int exp_err = 0;
   int exp_ovf = 0;
   int latency = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;
   bit reader_on = 1'b0;
   bit manual_rd = 1'b0;

   always #5 sys_clk = ~sys_clk;

   ps2_rx_fifo #(
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .FIFO_AW    (FIFO_AW)
   ) dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .frame_err(frame_err),
      .overflow (overflow),
      .busy     (busy)
   );

   task automatic check_output(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, req, req);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   // Reader: random pops when enabled, otherwise follows the manual strobe.
   initial begin
      forever begin
         @(posedge sys_clk);
         #1;
         rd_en = reader_on ? 1'($urandom_range(0, 1)) : manual_rd;
      end
   end

   // Monitor: every accepted pop is compared against the head of the expected queue.
   initial begin
      forever begin
         @(negedge sys_clk);
         if (sys_rst_n) begin
            if (frame_err) act_err++;
            if (overflow) act_ovf++;
            if (rd_en && rd_valid) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_pop actual=0x%02h required=no data", rd_data);
               end else begin
                  mon_exp = exp_q.pop_front();
                  check_output("pop_data", int'(rd_data), int'(mon_exp));
               end
            end
         end
      end
   end

   // Drives nbits of a frame (start, data LSB first, odd parity, stop) and updates the model for full frames.
   task automatic apply_stimulus(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                                 input int hp, input int nbits, input int glitch_bit, input bit measure);
      logic [10:0] bits;
      int n;
      bits = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
      if (nbits == 11) begin
         if (bad_par || bad_stop) exp_err++;
         else if (exp_q.size() < DEPTH) exp_q.push_back(d);
         else exp_ovf++;
      end
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         if (i == glitch_bit) begin
            wait_cycles(hp / 2);
            ps2_clk = 1'b0;
            wait_cycles(3);
            ps2_clk = 1'b1;
            wait_cycles(hp - hp / 2 - 3);
         end else begin
            wait_cycles(hp);
         end
         ps2_clk = 1'b0;
         if (measure && i == 10) begin
            n = 0;
            @(negedge sys_clk);
            while (!rd_valid && n < 200) begin
               @(negedge sys_clk);
               n++;
            end
            latency = n;
         end
         wait_cycles(hp);
         ps2_clk = 1'b1;
      end
      if (nbits == 11) begin
         ps2_data = 1'b1;
         wait_cycles(hp);
      end
   endtask

   task automatic drain();
      int n;
      reader_on = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         wait_cycles(1);
         n++;
      end
      check_output("drain_left", exp_q.size(), 0);
      reader_on = 1'b0;
      wait_cycles(4);
      check_output("empty_after_drain", int'(rd_valid), 0);
   endtask

   initial begin
      #1_500_000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] d;
      bit bp, bs;
      wait_cycles(3);
      check_output("reset_rd_valid", int'(rd_valid), 0);
      check_output("reset_rd_data", int'(rd_data), 0);
      check_output("reset_frame_err", int'(frame_err), 0);
      check_output("reset_overflow", int'(overflow), 0);
      check_output("reset_busy", int'(busy), 0);
      sys_rst_n = 1'b1;
      wait_cycles(20);

      // Clean frame with latency measurement on the stop-bit falling edge.
      apply_stimulus(8'h1C, 1'b0, 1'b0, 1000, 11, -1, 1'b1);
      check_output("latency", latency, FILTER_LEN + 5);
      check_output("clean_frame_err", act_err, 0);
      check_output("clean_head", int'(rd_data), 8'h1C);
      drain();

      // Bad parity: no push, one error pulse.
      apply_stimulus(8'h1C, 1'b1, 1'b0, 60, 11, -1, 1'b0);
      check_output("badpar_rd_valid", int'(rd_valid), 0);
      check_output("badpar_err_count", act_err, exp_err);

      // Short glitches while idle and mid-frame are ignored.
      ps2_clk = 1'b0;
      wait_cycles(3);
      ps2_clk = 1'b1;
      wait_cycles(40);
      check_output("glitch_idle_busy", int'(busy), 0);
      apply_stimulus(8'hF0, 1'b0, 1'b0, 60, 11, 4, 1'b0);
      drain();
      check_output("glitch_err_count", act_err, exp_err);

      // Timeout after start + 4 data bits.
      apply_stimulus(8'h00, 1'b0, 1'b0, 60, 5, -1, 1'b0);
      ps2_data = 1'b1;
      check_output("timeout_busy_mid", int'(busy), 1);
      exp_err++;
      wait_cycles(TIMEOUT_CYC + 100);
      check_output("timeout_busy_after", int'(busy), 0);
      check_output("timeout_err_count", act_err, exp_err);
      apply_stimulus(8'hAA, 1'b0, 1'b0, 60, 11, -1, 1'b0);
      drain();

      // Overflow: five bytes into a four-deep FIFO with no reads.
      for (int v = 1; v <= 5; v++) begin
         apply_stimulus(8'(v), 1'b0, 1'b0, 50, 11, -1, 1'b0);
      end
      check_output("overflow_count", act_ovf, exp_ovf);
      check_output("overflow_head", int'(rd_data), 8'h01);
      @(negedge sys_clk);
      manual_rd = 1'b1;
      repeat (4) @(negedge sys_clk);
      manual_rd = 1'b0;
      wait_cycles(3);
      check_output("popped_all_rd_valid", int'(rd_valid), 0);
      @(negedge sys_clk);
      manual_rd = 1'b1;
      @(negedge sys_clk);
      manual_rd = 1'b0;
      wait_cycles(3);
      check_output("empty_pop_rd_valid", int'(rd_valid), 0);
      check_output("empty_pop_overflow", act_ovf, exp_ovf);
      apply_stimulus(8'h33, 1'b0, 1'b0, 50, 11, -1, 1'b0);
      drain();

      // Reset mid-frame with two bytes queued.
      apply_stimulus(8'h11, 1'b0, 1'b0, 60, 11, -1, 1'b0);
      apply_stimulus(8'h22, 1'b0, 1'b0, 60, 11, -1, 1'b0);
      check_output("prereset_rd_valid", int'(rd_valid), 1);
      apply_stimulus(8'h6B, 1'b0, 1'b0, 60, 7, -1, 1'b0);
      check_output("prereset_busy", int'(busy), 1);
      sys_rst_n = 1'b0;
      exp_q.delete();
      wait_cycles(1);
      sys_rst_n = 1'b1;
      ps2_data = 1'b1;
      wait_cycles(2);
      check_output("postreset_rd_valid", int'(rd_valid), 0);
      check_output("postreset_busy", int'(busy), 0);
      check_output("postreset_rd_data", int'(rd_data), 0);
      wait_cycles(50);
      check_output("postreset_err_count", act_err, exp_err);
      apply_stimulus(8'h5A, 1'b0, 1'b0, 60, 11, -1, 1'b0);
      check_output("postreset_head", int'(rd_data), 8'h5A);
      drain();

      // Randomised frames with a random reader running.
      reader_on = 1'b1;
      for (int k = 0; k < 12; k++) begin
         d  = 8'($urandom);
         bp = ($urandom_range(0, 5) == 0);
         bs = ($urandom_range(0, 5) == 0);
         apply_stimulus(d, bp, bs, $urandom_range(40, 80), 11, -1, 1'b0);
      end
      drain();
      check_output("final_err_count", act_err, exp_err);
      check_output("final_ovf_count", act_ovf, exp_ovf);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
